// File: rtl/gf180mcu_osu_sc_gp9t3v3__tbuf_pkg.sv
// Shared definitions for the tri-state bus controller.
//   bus_state_t : controller FSM states (idle, driving, turnaround dead time)
//   owner_w()   : width of a source index for a given source count
package gf180mcu_osu_sc_gp9t3v3__tbuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } bus_state_t;

  function automatic int unsigned owner_w(input int unsigned n);
    if (n < 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp9t3v3__rr_arb.sv
// Combinational round-robin arbiter.
//   req     : per-source request vector
//   owner   : index of the current/last owner; search starts at owner+1
//   win_oh  : one-hot winner (all zero when nobody requests)
//   win_idx : index of the winner
//   any_req : at least one request is present
module gf180mcu_osu_sc_gp9t3v3__rr_arb
  import gf180mcu_osu_sc_gp9t3v3__tbuf_pkg::*;
#(
  parameter int unsigned NSRC = 4,
  localparam int unsigned OWNER_W = owner_w(NSRC)
) (
  input  logic [NSRC-1:0]    req,
  input  logic [OWNER_W-1:0] owner,
  output logic [NSRC-1:0]    win_oh,
  output logic [OWNER_W-1:0] win_idx,
  output logic               any_req
);

  logic               found;
  logic [OWNER_W-1:0] cand;

  // Scan owner+1, owner+2, ... wrapping; the last candidate is owner itself.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NSRC; k++) begin
      cand = OWNER_W'((32'(owner) + k) % NSRC);
      if (!found && req[cand]) begin
        found        = 1'b1;
        win_oh[cand] = 1'b1;
        win_idx      = cand;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/gf180mcu_osu_sc_gp9t3v3__tbuf_bus_ctrl.sv
// Controller for a shared tri-state bus built from tbuf cells.
//   CLK, RST  : rising-edge clock, synchronous active-high reset
//   REQ       : per-source level-sensitive bus request
//   DIN       : source data, source i at DIN[i*WIDTH +: WIDTH]
//   GNT/EN    : registered one-hot grant / tbuf enable (identical)
//   EN_BAR    : complement of EN, held in its own flop bank
//   BUS       : owner's data while driving, else the keeper value
//   BUS_VALID : a source is driving the bus
//   OWNER     : index of current or last owner
// Break-before-make: after every release the bus spends TURN cycles in
// turnaround plus at least one idle cycle with all enables low.
module gf180mcu_osu_sc_gp9t3v3__tbuf_bus_ctrl
  import gf180mcu_osu_sc_gp9t3v3__tbuf_pkg::*;
#(
  parameter int unsigned NSRC     = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TURN     = 1,
  parameter int unsigned MAX_HOLD = 0,
  localparam int unsigned OWNER_W = owner_w(NSRC)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NSRC-1:0]         REQ,
  input  logic [NSRC*WIDTH-1:0]   DIN,
  output logic [NSRC-1:0]         GNT,
  output logic [NSRC-1:0]         EN,
  output logic [NSRC-1:0]         EN_BAR,
  output logic [WIDTH-1:0]        BUS,
  output logic                    BUS_VALID,
  output logic [OWNER_W-1:0]      OWNER
);

  localparam int unsigned TURN_W = (TURN < 2) ? 1 : $clog2(TURN);
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 2);

  bus_state_t         state_q, state_d;
  logic [NSRC-1:0]    gnt_q, gnt_d;
  logic [NSRC-1:0]    en_bar_q;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [TURN_W-1:0]  turn_q, turn_d;
  logic [HOLD_W-1:0]  hold_q, hold_d, hold_inc;
  logic [WIDTH-1:0]   keeper_q, keeper_d;
  logic [WIDTH-1:0]   din_arr [NSRC];
  logic [NSRC-1:0]    win_oh;
  logic [OWNER_W-1:0] win_idx;
  logic               any_req;
  logic               owner_req;
  logic               other_req;
  logic               forced;

  gf180mcu_osu_sc_gp9t3v3__rr_arb #(
    .NSRC(NSRC)
  ) u_arb (
    .req     (REQ),
    .owner   (owner_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  always_comb begin
    for (int unsigned i = 0; i < NSRC; i++) begin
      din_arr[i] = DIN[i*WIDTH +: WIDTH];
    end
  end

  // In DRIVE gnt_q is the owner's one-hot, so it masks owner vs. others.
  assign owner_req = |(REQ & gnt_q);
  assign other_req = |(REQ & ~gnt_q);
  assign hold_inc  = (hold_q == '1) ? hold_q : hold_q + 1'b1;
  // hold_inc counts the current DRIVE cycle, so release happens after
  // exactly MAX_HOLD driven cycles.
  assign forced    = (MAX_HOLD != 0) && (32'(hold_inc) >= MAX_HOLD) && other_req;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    turn_d   = turn_q;
    hold_d   = hold_q;
    keeper_d = keeper_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_DRIVE;
          gnt_d   = win_oh;
          owner_d = win_idx;
          hold_d  = '0;
        end
      end
      ST_DRIVE: begin
        keeper_d = din_arr[owner_q];
        hold_d   = hold_inc;
        if (!owner_req || forced) begin
          state_d = ST_TURN;
          gnt_d   = '0;
          turn_d  = TURN_W'(TURN - 1);
        end
      end
      ST_TURN: begin
        if (turn_q == '0) state_d = ST_IDLE;
        else              turn_d  = turn_q - 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      en_bar_q <= '1;
      owner_q  <= OWNER_W'(NSRC - 1);
      turn_q   <= '0;
      hold_q   <= '0;
      keeper_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      en_bar_q <= ~gnt_d;
      owner_q  <= owner_d;
      turn_q   <= turn_d;
      hold_q   <= hold_d;
      keeper_q <= keeper_d;
    end
  end

  assign GNT       = gnt_q;
  assign EN        = gnt_q;
  assign EN_BAR    = en_bar_q;
  assign OWNER     = owner_q;
  assign BUS_VALID = (state_q == ST_DRIVE);
  assign BUS       = (state_q == ST_DRIVE) ? din_arr[owner_q] : keeper_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__tbuf_bus_ctrl.sv
module tb_gf180mcu_osu_sc_gp9t3v3__tbuf_bus_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic [3:0]  en;
  logic [3:0]  en_bar;
  logic [7:0]  bus;
  logic        bus_valid;
  logic [1:0]  owner;

  int total = 0;
  int bad   = 0;

  gf180mcu_osu_sc_gp9t3v3__tbuf_bus_ctrl #(
    .NSRC(4),
    .WIDTH(8),
    .TURN(1),
    .MAX_HOLD(4)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ       (req),
    .DIN       (din),
    .GNT       (gnt),
    .EN        (en),
    .EN_BAR    (en_bar),
    .BUS       (bus),
    .BUS_VALID (bus_valid),
    .OWNER     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (gnt == 4'b0000 && n < 20) begin
      tick();
      n++;
    end
    if (gnt == 4'b0000) chk("wait_gnt_timeout", 32'(gnt != 4'b0000), 32'd1);
  endtask

  // Per-cycle invariants and break-before-make gap check, sampled mid-cycle.
  logic [3:0] en_inv;
  logic [3:0] prev_gnt = '0;
  int         zeros    = 0;
  bit         have     = 1'b0;

  always @(negedge clk) begin
    en_inv = ~en;
    chk("inv_onehot", 32'($onehot0(gnt)), 32'd1);
    chk("inv_en", en, gnt);
    chk("inv_enb", en_bar, en_inv);
    chk("inv_valid", bus_valid, |gnt);
    if (bus_valid) begin
      chk("mon_bus", bus, din[owner*8 +: 8]);
      chk("mon_owner", gnt, 32'(1) << owner);
    end
    if (rst) begin
      have  = 1'b0;
      zeros = 0;
    end else if (gnt == 4'b0000) begin
      zeros++;
    end else if (gnt != prev_gnt) begin
      if (have) chk("gap_min", 32'(zeros >= 2), 32'd1);
      have  = 1'b1;
      zeros = 0;
    end
    prev_gnt = gnt;
  end

  initial begin
    int n;
    int e;

    // Reset with all sources requesting
    rst = 1'b1;
    req = 4'b1111;
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    tick();
    chk("rst_gnt", gnt, 32'h0);
    chk("rst_en", en, 32'h0);
    chk("rst_enb", en_bar, 32'hF);
    chk("rst_bus", bus, 32'h0);
    chk("rst_valid", bus_valid, 32'h0);
    chk("rst_owner", owner, 32'd3);
    rst = 1'b0;
    tick();
    chk("first_gnt", gnt, 32'h1);
    chk("first_valid", bus_valid, 32'h1);
    chk("first_bus", bus, 32'h11);
    chk("first_owner", owner, 32'd0);
    req = 4'b0000;
    tick();
    chk("rel_gnt", gnt, 32'h0);
    chk("rel_bus", bus, 32'h11);
    tick();
    tick();

    // Round robin between sources 1 and 3
    req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      e = (i % 2 == 0) ? 1 : 3;
      wait_grant(n);
      if (i == 0) chk("rr_lat", n, 32'd1);
      else        chk("rr_gap", n, 32'd2);
      chk("rr_gnt", gnt, 32'(1) << e);
      chk("rr_owner", owner, e);
      tick();
      tick();
      chk("rr_hold", gnt, 32'(1) << e);
      req[e] = 1'b0;
      tick();
      chk("rr_drop", gnt, 32'h0);
      req[e] = 1'b1;
    end
    req = 4'b0000;
    tick();
    tick();
    tick();

    // Keeper holds last driven value
    din[23:16] = 8'hA5;
    req = 4'b0100;
    tick();
    chk("kp_gnt", gnt, 32'h4);
    chk("kp_bus", bus, 32'hA5);
    chk("kp_valid", bus_valid, 32'h1);
    req = 4'b0000;
    tick();
    chk("kp_turn_bus", bus, 32'hA5);
    chk("kp_turn_valid", bus_valid, 32'h0);
    din[23:16] = 8'h5A;
    tick();
    chk("kp_idle_bus", bus, 32'hA5);
    chk("kp_idle_valid", bus_valid, 32'h0);
    tick();
    chk("kp_idle_bus2", bus, 32'hA5);

    // Forced release after 4 drive cycles
    req = 4'b0001;
    tick();
    chk("fr_gnt0", gnt, 32'h1);
    tick();
    req = 4'b0011;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("fr_hold", gnt, 32'h1);
    end
    tick();
    chk("fr_rel", gnt, 32'h0);
    tick();
    chk("fr_idle", gnt, 32'h0);
    tick();
    chk("fr_next", gnt, 32'h2);
    chk("fr_owner", owner, 32'd1);
    req = 4'b0000;
    tick();
    tick();

    // Reset in the middle of a drive
    req = 4'b0100;
    tick();
    chk("mr_en", en, 32'h4);
    rst = 1'b1;
    req = 4'b1111;
    tick();
    chk("mr_en0", en, 32'h0);
    chk("mr_enb", en_bar, 32'hF);
    chk("mr_owner", owner, 32'd3);
    chk("mr_valid", bus_valid, 32'h0);
    chk("mr_bus", bus, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(n);
      chk("mr_order", gnt, 32'(1) << k);
      req[k] = 1'b0;
      tick();
    end
    tick();
    tick();

    // Random requests; invariants checked by the monitor
    for (int r = 0; r < 400; r++) begin
      req = 4'($urandom);
      din = $urandom;
      tick();
    end
    req = 4'b0000;
    for (int r = 0; r < 6; r++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
